// File: rtl/fifo_push_arbiter_if.sv
// Producer-side request bus plus FIFO push/clear/pop wiring shared by the
// push arbiter. The master modport is the environment (producers, consumer,
// flush source); the slave modport is the arbiter itself.
interface fifo_push_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CNTW  = $clog2(DEPTH) + 1
);
   localparam int GW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  flush;
   logic                  fifo_pop;
   logic                  fifo_push;
   logic [WIDTH-1:0]      fifo_data;
   logic                  fifo_clr;
   logic [GW-1:0]         grant_id;
   logic [CNTW-1:0]       level;
   logic                  pop_err;

   modport master (
      output req_valid, req_data, flush, fifo_pop,
      input  req_ready, fifo_push, fifo_data, fifo_clr, grant_id, level, pop_err
   );

   modport slave (
      input  req_valid, req_data, flush, fifo_pop,
      output req_ready, fifo_push, fifo_data, fifo_clr, grant_id, level, pop_err
   );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NREQ requesters.
// A credit counter (level) covers both stored words and the in-flight
// registered push, so the FIFO never sees a push while full. Also sequences
// a two-cycle synchronous flush and flags pops issued against an empty FIFO.
module fifo_push_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input logic                clk,
   input logic                rst,
   fifo_push_arbiter_if.slave bus
);
   localparam int GW = $clog2(NREQ);

   logic [GW-1:0]    rr_ptr_r;
   logic             flush_pend_r;
   logic [CNTW-1:0]  level_r;
   logic             push_r;
   logic [WIDTH-1:0] data_r;
   logic             clr_r;
   logic [GW-1:0]    gid_r;
   logic             pop_err_r;

   logic [WIDTH-1:0] lane_s [NREQ];
   logic [GW-1:0]    grant_s;
   logic [GW-1:0]    scan_idx_s;
   logic             found_s;
   logic             can_acc_s;
   logic             acc_s;
   logic             pop_s;
   logic [CNTW-1:0]  level_nxt_s;
   logic [GW-1:0]    rr_nxt_s;
   logic [NREQ-1:0]  req_ready_s;

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign lane_s[i] = bus.req_data[i*WIDTH +: WIDTH];
   end

   // Scan requesters starting at rr_ptr; first valid one is the grant.
   always_comb begin
      grant_s    = {GW{1'b0}};
      found_s    = 1'b0;
      scan_idx_s = {GW{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         scan_idx_s = GW'((int'(rr_ptr_r) + k) % NREQ);
         if (!found_s && bus.req_valid[scan_idx_s]) begin
            grant_s = scan_idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Accept only with a free credit, outside reset and outside any flush;
   // fifo_pop deliberately does not feed this path.
   always_comb begin
      can_acc_s = rst & (level_r < CNTW'(DEPTH)) & ~bus.flush & ~flush_pend_r;
      acc_s     = can_acc_s & found_s;
      pop_s     = bus.fifo_pop & (level_r != CNTW'(0));
      rr_nxt_s  = GW'((int'(grant_s) + 1) % NREQ);
   end

   // Credit update: +1 per accept, -1 per legal pop, net zero when both.
   always_comb begin
      level_nxt_s = level_r;
      case ({acc_s, pop_s})
         2'b10:   level_nxt_s = level_r + CNTW'(1);
         2'b01:   level_nxt_s = level_r - CNTW'(1);
         default: level_nxt_s = level_r;
      endcase
   end

   // One-hot ready toward the granted requester, zero when not accepting.
   always_comb begin
      req_ready_s = {NREQ{1'b0}};
      if (acc_s) begin
         req_ready_s[grant_s] = 1'b1;
      end else begin
         req_ready_s = {NREQ{1'b0}};
      end
   end

   // State and registered FIFO-side outputs; flush forces the clear cycle
   // and discards credits, while reset holds the FIFO clear asserted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_r     <= {GW{1'b0}};
         flush_pend_r <= 1'b0;
         level_r      <= {CNTW{1'b0}};
         push_r       <= 1'b0;
         data_r       <= {WIDTH{1'b0}};
         clr_r        <= 1'b1;
         gid_r        <= {GW{1'b0}};
         pop_err_r    <= 1'b0;
      end else begin
         clr_r        <= bus.flush;
         flush_pend_r <= bus.flush;
         pop_err_r    <= pop_err_r | (bus.fifo_pop & (level_r == CNTW'(0)) &
                                      ~bus.flush & ~flush_pend_r);
         if (bus.flush) begin
            push_r   <= 1'b0;
            level_r  <= {CNTW{1'b0}};
            rr_ptr_r <= {GW{1'b0}};
         end else begin
            push_r  <= acc_s;
            level_r <= level_nxt_s;
            if (acc_s) begin
               data_r   <= lane_s[grant_s];
               gid_r    <= grant_s;
               rr_ptr_r <= rr_nxt_s;
            end else begin
               rr_ptr_r <= rr_ptr_r;
            end
         end
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.fifo_push = push_r;
   assign bus.fifo_data = data_r;
   assign bus.fifo_clr  = clr_r;
   assign bus.grant_id  = gid_r;
   assign bus.level     = level_r;
   assign bus.pop_err   = pop_err_r;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: expected {grant_id, data} pairs are
// queued when an accept is expected and a negedge monitor retires them on
// every fifo_push. A small FIFO occupancy model flags pushes into a full FIFO.
module tb_fifo_push_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   logic clk;
   logic rst;
   logic [7:0] lane [NREQ];
   logic [9:0] sb_q [$];
   int n_checks = 0;
   int n_err    = 0;
   int occ_m    = 0;

   fifo_push_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

   fifo_push_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   assign bus.req_data = {lane[3], lane[2], lane[1], lane[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic expect_push(input int g, input logic [7:0] d);
      sb_q.push_back({2'(g), d});
   endtask

   // Monitor: retire one expected entry per push, check FIFO not full, and
   // advance the FIFO occupancy model for the coming edge.
   always @(negedge clk) begin
      if (bus.fifo_push) begin
         chk("push_into_full_fifo", 32'(occ_m >= DEPTH), 32'd0);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_push: actual push grant_id %0d data 0x%0h, required no push",
                     bus.grant_id, bus.fifo_data);
         end else begin
            chk("grant_id", 32'(bus.grant_id), 32'(sb_q[0][9:8]));
            chk("fifo_data", 32'(bus.fifo_data), 32'(sb_q[0][7:0]));
            void'(sb_q.pop_front());
         end
      end
      if (bus.fifo_clr) occ_m <= 0;
      else occ_m <= occ_m + (bus.fifo_push ? 1 : 0) - ((bus.fifo_pop && occ_m > 0) ? 1 : 0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      bus.req_valid = 4'hF;
      bus.flush = 1'b0;
      bus.fifo_pop = 1'b0;
      for (int i = 0; i < NREQ; i++) lane[i] = 8'hA0 + 8'(i);

      // Reset values, with all requesters valid to show ready is gated.
      smp();
      smp();
      chk("rst_push", 32'(bus.fifo_push), 32'd0);
      chk("rst_data", 32'(bus.fifo_data), 32'd0);
      chk("rst_clr", 32'(bus.fifo_clr), 32'd1);
      chk("rst_gid", 32'(bus.grant_id), 32'd0);
      chk("rst_level", 32'(bus.level), 32'd0);
      chk("rst_pop_err", 32'(bus.pop_err), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);

      // All four valid, no pops: grants 0,1,2,3,0,1,2,3 then full.
      cyc();
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         smp();
         chk("p1_ready", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
         chk("p1_level", 32'(bus.level), 32'(k));
         if (k == 1) chk("p1_clr_released", 32'(bus.fifo_clr), 32'd0);
         expect_push(k % 4, 8'hA0 + 8'(k % 4));
         cyc();
      end
      smp();
      chk("p1_level_full", 32'(bus.level), 32'd8);
      chk("p1_ready_full", 32'(bus.req_ready), 32'd0);
      cyc();
      smp();
      chk("p1_ready_full2", 32'(bus.req_ready), 32'd0);
      cyc();

      // Full: one pop frees a credit next cycle, req0 takes it.
      bus.req_valid = 4'b0001;
      lane[0] = 8'h55;
      bus.fifo_pop = 1'b1;
      smp();
      chk("p2_ready_pop_same", 32'(bus.req_ready), 32'd0);
      cyc();
      bus.fifo_pop = 1'b0;
      smp();
      chk("p2_level7", 32'(bus.level), 32'd7);
      chk("p2_ready", 32'(bus.req_ready), 32'd1);
      expect_push(0, 8'h55);
      cyc();
      smp();
      chk("p2_level8", 32'(bus.level), 32'd8);
      chk("p2_ready_full", 32'(bus.req_ready), 32'd0);
      cyc();

      // Drain to 3, then accept+pop together for five cycles.
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 4'b0000;
         bus.fifo_pop = 1'b1;
         smp();
         chk("p3_drain_level", 32'(bus.level), 32'(8 - i));
         cyc();
      end
      for (int i = 0; i < NREQ; i++) lane[i] = 8'h10 + 8'(i);
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 4'hF;
         bus.fifo_pop = 1'b1;
         smp();
         chk("p3_level", 32'(bus.level), 32'd3);
         chk("p3_ready", 32'(bus.req_ready), 32'(4'b0001 << ((1 + i) % 4)));
         expect_push((1 + i) % 4, 8'h10 + 8'((1 + i) % 4));
         cyc();
      end
      bus.req_valid = 4'b0000;
      bus.fifo_pop = 1'b0;
      smp();
      chk("p3_level_after", 32'(bus.level), 32'd3);
      cyc();

      // Only req2 valid: first from rr_ptr=2, then with rr_ptr=3.
      bus.req_valid = 4'b0100;
      smp();
      chk("p4_ready_a", 32'(bus.req_ready), 32'b0100);
      expect_push(2, 8'h12);
      cyc();
      lane[2] = 8'h77;
      smp();
      chk("p4_ready_b", 32'(bus.req_ready), 32'b0100);
      expect_push(2, 8'h77);
      cyc();
      bus.req_valid = 4'b1101;
      smp();
      chk("p4_rr_after_wrap", 32'(bus.req_ready), 32'b1000);
      chk("p4_level", 32'(bus.level), 32'd5);
      expect_push(3, 8'h13);
      cyc();

      // Accept at t-1, flush at t, clear at t+1, resume at t+2.
      bus.req_valid = 4'b0001;
      smp();
      chk("p5_ready_tm1", 32'(bus.req_ready), 32'd1);
      chk("p5_level_tm1", 32'(bus.level), 32'd6);
      expect_push(0, 8'h10);
      cyc();
      bus.req_valid = 4'hF;
      bus.flush = 1'b1;
      bus.fifo_pop = 1'b1;
      smp();
      chk("p5_ready_t", 32'(bus.req_ready), 32'd0);
      chk("p5_push_t", 32'(bus.fifo_push), 32'd1);
      cyc();
      bus.flush = 1'b0;
      smp();
      chk("p5_clr_t1", 32'(bus.fifo_clr), 32'd1);
      chk("p5_push_t1", 32'(bus.fifo_push), 32'd0);
      chk("p5_level_t1", 32'(bus.level), 32'd0);
      chk("p5_ready_t1", 32'(bus.req_ready), 32'd0);
      cyc();
      bus.fifo_pop = 1'b0;
      smp();
      chk("p5_clr_t2", 32'(bus.fifo_clr), 32'd0);
      chk("p5_pop_err_t2", 32'(bus.pop_err), 32'd0);
      chk("p5_level_t2", 32'(bus.level), 32'd0);
      chk("p5_fifo_empty_t2", 32'(occ_m), 32'd0);
      chk("p5_ready_t2", 32'(bus.req_ready), 32'd1);
      expect_push(0, 8'h10);
      cyc();

      // Drain, then pop on empty: sticky pop_err through later accepts.
      bus.req_valid = 4'b0000;
      smp();
      chk("p6_level1", 32'(bus.level), 32'd1);
      cyc();
      bus.fifo_pop = 1'b1;
      smp();
      chk("p6_pop_err_clear", 32'(bus.pop_err), 32'd0);
      cyc();
      smp();
      chk("p6_level0", 32'(bus.level), 32'd0);
      cyc();
      bus.fifo_pop = 1'b0;
      bus.req_valid = 4'hF;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("p6_pop_err_sticky", 32'(bus.pop_err), 32'd1);
         chk("p6_ready", 32'(bus.req_ready), 32'(4'b0001 << (1 + i)));
         expect_push(1 + i, lane[1 + i]);
         cyc();
      end

      // Asynchronous reset mid-push clears everything at once.
      #1;
      rst = 1'b0;
      #1;
      chk("ar_push", 32'(bus.fifo_push), 32'd0);
      chk("ar_data", 32'(bus.fifo_data), 32'd0);
      chk("ar_clr", 32'(bus.fifo_clr), 32'd1);
      chk("ar_gid", 32'(bus.grant_id), 32'd0);
      chk("ar_level", 32'(bus.level), 32'd0);
      chk("ar_pop_err", 32'(bus.pop_err), 32'd0);
      chk("ar_ready", 32'(bus.req_ready), 32'd0);
      sb_q.delete();
      smp();
      cyc();
      rst = 1'b1;
      bus.req_valid = 4'hF;
      smp();
      chk("rel_clr_before_edge", 32'(bus.fifo_clr), 32'd1);
      chk("rel_ready", 32'(bus.req_ready), 32'd1);
      expect_push(0, 8'h10);
      cyc();
      bus.req_valid = 4'b0000;
      smp();
      chk("rel_clr_after_edge", 32'(bus.fifo_clr), 32'd0);
      chk("rel_level", 32'(bus.level), 32'd1);
      cyc();
      cyc();
      smp();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
